// File: rtl/cmp_pkg.sv
// Shared definitions for comparator-mask producers and consumers.
//  - MASK_TRUE / MASK_FALSE : canonical 8-bit encodings of a compare result
//  - state_t                : packer FSM states
//  - count_width()          : width of a counter that must hold 0..n
package cmp_pkg;

   localparam logic [7:0] MASK_TRUE  = 8'hFF;
   localparam logic [7:0] MASK_FALSE = 8'h00;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   function automatic int unsigned count_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cmp_mask_decode.sv
// Combinational decode of one comparator mask into a 1-bit flag.
// Ports:
//  mask      in   MASK_W  incoming compare mask
//  flag      out  1       decoded flag (MSB of the mask)
//  malformed out  1       mask is neither all-ones nor all-zeros
// For well-formed masks the MSB equals the flag, and a malformed mask
// decodes to its MSB, so the flag is always the MSB; consumers that drop
// malformed masks use the malformed indication to ignore it.
module cmp_mask_decode #(
   parameter int unsigned MASK_W = 8
) (
   input  logic [MASK_W-1:0] mask,
   output logic              flag,
   output logic              malformed
);

   localparam logic [MASK_W-1:0] ONES  = '1;
   localparam logic [MASK_W-1:0] ZEROS = '0;

   always_comb begin
      flag      = mask[MASK_W-1];
      malformed = (mask != ONES) && (mask != ZEROS);
   end

endmodule

// File: rtl/cmp_mask_packer.sv
// Decodes a stream of comparator masks into flags and packs PACK_N of them
// per output word, handed downstream over valid/ready.
// Ports:
//  clk, rst   clock (rising edge), asynchronous active-high reset
//  in_valid   in   beat valid
//  in_ready   out  beat accepted this cycle (low in HOLD and during reset)
//  in_mask    in   compare mask (all-ones = 1, all-zeros = 0)
//  in_last    in   last beat of a group; flushes a partial word
//  out_valid  out  packed word available
//  out_ready  in   downstream accepts the word
//  out_flags  out  packed flags, bit i = i-th accepted flag
//  out_count  out  number of valid flags in out_flags
//  out_err    out  a malformed mask occurred in this word (sticky per word)
// Build option: define CMP_PACK_STRICT_EN to drop malformed masks instead of
// packing their MSB.
module cmp_mask_packer
   import cmp_pkg::*;
#(
   parameter int unsigned MASK_W = 8,
   parameter int unsigned PACK_N = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [MASK_W-1:0]                 in_mask,
   input  logic                              in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [PACK_N-1:0]                 out_flags,
   output logic [count_width(PACK_N)-1:0]    out_count,
   output logic                              out_err
);

   localparam int unsigned CW = count_width(PACK_N);

   state_t            state, state_d;
   logic              ready_d;
   logic              valid_d;
   logic [PACK_N-1:0] flags_d;
   logic [CW-1:0]     count_d;
   logic              err_d;
   logic              pack;
   logic              beat_flag;
   logic              beat_bad;

   cmp_mask_decode #(
      .MASK_W (MASK_W)
   ) u_decode (
      .mask      (in_mask),
      .flag      (beat_flag),
      .malformed (beat_bad)
   );

   // State and output registers; out_flags doubles as the packing register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_flags <= '0;
         out_count <= '0;
         out_err   <= 1'b0;
      end else begin
         state     <= state_d;
         in_ready  <= ready_d;
         out_valid <= valid_d;
         out_flags <= flags_d;
         out_count <= count_d;
         out_err   <= err_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state;
      ready_d = in_ready;
      valid_d = out_valid;
      flags_d = out_flags;
      count_d = out_count;
      err_d   = out_err;
      pack    = 1'b0;

      case (state)
         FILL: begin
            ready_d = 1'b1;
            if (in_valid && in_ready) begin
`ifdef CMP_PACK_STRICT_EN
               pack = !beat_bad;
`else
               pack = 1'b1;
`endif
               if (beat_bad) begin
                  err_d = 1'b1;
               end
               if (pack) begin
                  for (int i = 0; i < int'(PACK_N); i++) begin
                     if (CW'(i) == out_count) begin
                        flags_d[i] = beat_flag;
                     end
                  end
                  count_d = out_count + CW'(1);
               end
               // A last beat with nothing packed keeps err pending for the next word.
               if ((count_d == CW'(PACK_N)) || (in_last && (count_d != '0))) begin
                  state_d = HOLD;
                  valid_d = 1'b1;
                  ready_d = 1'b0;
               end
            end
         end

         HOLD: begin
            ready_d = 1'b0;
            if (out_valid && out_ready) begin
               state_d = FILL;
               valid_d = 1'b0;
               flags_d = '0;
               count_d = '0;
               err_d   = 1'b0;
               ready_d = 1'b1;
            end
         end

         default: begin
            state_d = FILL;
         end
      endcase
   end

endmodule

// File: tb/tb_cmp_mask_packer.sv
// Self-checking bench for cmp_mask_packer: directed scenarios plus a
// randomized stream checked against a queue-based reference model.
module tb_cmp_mask_packer;
   import cmp_pkg::*;

   localparam int unsigned PACK_N = 8;

   typedef struct {
      logic [7:0] m;
      logic       l;
   } beat_t;

   typedef struct {
      logic [7:0] f;
      logic [3:0] c;
      logic       e;
   } word_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_mask;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_flags;
   logic [3:0] out_count;
   logic       out_err;

   int pass_cnt  = 0;
   int check_cnt = 0;

   beat_t stim_q[$];
   word_t exp_q[$];

   cmp_mask_packer #(
      .MASK_W (8),
      .PACK_N (PACK_N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mask   (in_mask),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_flags (out_flags),
      .out_count (out_count),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   // Present one beat and hold it until accepted (bounded wait).
   task automatic send_beat(input logic [7:0] m, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_mask  = m;
      in_last  = l;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check_cnt++;
         $display("FAIL send_beat_timeout in_ready=%b required 1", in_ready);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_mask  = 8'h00;
   endtask

   // Wait for a word, sample it, then complete the handshake.
   task automatic get_word(output logic [7:0] f, output logic [3:0] c, output logic e,
                           output bit got);
      int n = 0;
      got = 1'b0;
      f = '0; c = '0; e = 1'b0;
      while (out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (out_valid === 1'b1) begin
         got = 1'b1;
         f = out_flags;
         c = out_count;
         e = out_err;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   // Spec-level model: fill a flag list, emit on full or on last.
   function automatic void build_expected();
      bit    flags[$];
      bit    err;
      err = 1'b0;
      exp_q.delete();
      foreach (stim_q[k]) begin
         bit good;
         good = (stim_q[k].m == MASK_TRUE) || (stim_q[k].m == MASK_FALSE);
         if (!good) err = 1'b1;
`ifdef CMP_PACK_STRICT_EN
         if (good) flags.push_back(stim_q[k].m == MASK_TRUE);
`else
         flags.push_back(good ? (stim_q[k].m == MASK_TRUE) : stim_q[k].m[7]);
`endif
         if (flags.size() == PACK_N || (stim_q[k].l && flags.size() > 0)) begin
            word_t w;
            w.f = '0;
            foreach (flags[j]) w.f[j] = flags[j];
            w.c = 4'(flags.size());
            w.e = err;
            exp_q.push_back(w);
            flags.delete();
            err = 1'b0;
         end
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_mask = 8'h00; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_cnt++;
      if ({in_ready, out_valid, out_flags, out_count, out_err} !== 15'd0)
         $display("FAIL reset_outputs got rdy=%b vld=%b flags=%h cnt=%0d err=%b required all 0",
                  in_ready, out_valid, out_flags, out_count, out_err);
      else pass_cnt++;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_fill_ready got %b required 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_full_word();
      logic [7:0] seq [8] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
      logic [7:0] f; logic [3:0] c; logic e; bit got;
      for (int i = 0; i < 7; i++) send_beat(seq[i], 1'b0);
      check_cnt++;
      if (out_valid !== 1'b0) $display("FAIL full_early_valid got %b required 0", out_valid);
      else pass_cnt++;
      send_beat(seq[7], 1'b0);
      check_cnt++;
      if (out_valid !== 1'b1) $display("FAIL full_latency got %b required 1", out_valid);
      else pass_cnt++;
      get_word(f, c, e, got);
      check_cnt++;
      if (!got || f !== 8'h4D || c !== 4'd8 || e !== 1'b0)
         $display("FAIL full_word got=%b flags=%h cnt=%0d err=%b required flags=4d cnt=8 err=0",
                  got, f, c, e);
      else pass_cnt++;
   endtask

   task automatic test_partial();
      logic [7:0] f; logic [3:0] c; logic e; bit got;
      send_beat(8'hFF, 1'b0);
      send_beat(8'hFF, 1'b0);
      send_beat(8'h00, 1'b1);
      get_word(f, c, e, got);
      check_cnt++;
      if (!got || f !== 8'h03 || c !== 4'd3 || e !== 1'b0)
         $display("FAIL partial_word got=%b flags=%h cnt=%0d err=%b required flags=03 cnt=3 err=0",
                  got, f, c, e);
      else pass_cnt++;
   endtask

   task automatic test_malformed();
      logic [7:0] f; logic [3:0] c; logic e; bit got;
      logic [7:0] ef; logic [3:0] ec;
      send_beat(8'h80, 1'b0);
      for (int i = 0; i < 7; i++) send_beat(8'h00, 1'b0);
`ifdef CMP_PACK_STRICT_EN
      check_cnt++;
      if (out_valid !== 1'b0) $display("FAIL strict_dropped_valid got %b required 0", out_valid);
      else pass_cnt++;
      send_beat(8'h00, 1'b0);
      ef = 8'h00; ec = 4'd8;
`else
      ef = 8'h01; ec = 4'd8;
`endif
      get_word(f, c, e, got);
      check_cnt++;
      if (!got || f !== ef || c !== ec || e !== 1'b1)
         $display("FAIL malformed_word got=%b flags=%h cnt=%0d err=%b required flags=%h cnt=%0d err=1",
                  got, f, c, e, ef, ec);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      send_beat(8'hFF, 1'b0);
      send_beat(8'h00, 1'b1);
      // Beats offered during HOLD must be ignored.
      in_valid = 1'b1; in_mask = 8'hFF; in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_cnt++;
         if (out_valid !== 1'b1 || out_flags !== 8'h01 || out_count !== 4'd2 ||
             out_err !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL backpressure_hold cyc=%0d vld=%b flags=%h cnt=%0d err=%b rdy=%b required 1 01 2 0 0",
                     i, out_valid, out_flags, out_count, out_err, in_ready);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 4'd0)
         $display("FAIL backpressure_release vld=%b rdy=%b cnt=%0d required 0 1 0",
                  out_valid, in_ready, out_count);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] f; logic [3:0] c; logic e; bit got;
      bit seen;
      for (int i = 0; i < 4; i++) send_beat(8'hFF, 1'b0);
      check_cnt++;
      if (out_count !== 4'd4) $display("FAIL midword_count got %0d required 4", out_count);
      else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      check_cnt++;
      if ({in_ready, out_valid, out_flags, out_count, out_err} !== 15'd0)
         $display("FAIL midword_reset rdy=%b vld=%b flags=%h cnt=%0d err=%b required all 0",
                  in_ready, out_valid, out_flags, out_count, out_err);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      check_cnt++;
      if (seen) $display("FAIL midword_no_word got valid=1 required 0");
      else pass_cnt++;
      for (int i = 0; i < 8; i++) send_beat(8'hFF, 1'b0);
      get_word(f, c, e, got);
      check_cnt++;
      if (!got || f !== 8'hFF || c !== 4'd8 || e !== 1'b0)
         $display("FAIL midword_next got=%b flags=%h cnt=%0d err=%b required flags=ff cnt=8 err=0",
                  got, f, c, e);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int n_exp;
      stim_q.delete();
      for (int i = 0; i < 150; i++) begin
         beat_t b;
         int    sel;
         sel = $urandom_range(0, 7);
         if (sel == 0) begin
            do b.m = 8'($urandom); while (b.m == MASK_TRUE || b.m == MASK_FALSE);
         end else begin
            b.m = (sel > 3) ? MASK_TRUE : MASK_FALSE;
         end
         b.l = ($urandom_range(0, 5) == 0);
         if (i == 149) begin
            b.m = MASK_TRUE;
            b.l = 1'b1;
         end
         stim_q.push_back(b);
      end
      build_expected();
      n_exp = exp_q.size();
      fork
         begin : driver
            foreach (stim_q[k]) begin
               int idle;
               idle = $urandom_range(0, 2);
               for (int j = 0; j < idle; j++) @(negedge clk);
               send_beat(stim_q[k].m, stim_q[k].l);
            end
         end
         begin : receiver
            int got = 0;
            int cyc = 0;
            while (got < n_exp && cyc < 5000) begin
               @(negedge clk);
               cyc++;
               out_ready = ($urandom_range(0, 3) != 0);
               if (out_valid === 1'b1 && out_ready) begin
                  check_cnt++;
                  if (out_flags !== exp_q[got].f || out_count !== exp_q[got].c ||
                      out_err !== exp_q[got].e)
                     $display("FAIL random_word idx=%0d flags=%h cnt=%0d err=%b required flags=%h cnt=%0d err=%b",
                              got, out_flags, out_count, out_err,
                              exp_q[got].f, exp_q[got].c, exp_q[got].e);
                  else pass_cnt++;
                  got++;
               end
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check_cnt++;
            if (got != n_exp) $display("FAIL random_timeout words=%0d required %0d", got, n_exp);
            else pass_cnt++;
         end
      join
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_malformed();
      test_backpressure();
      test_reset_mid_word();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
